// File: rtl/alu_pkg.sv
// Shared ALU definitions for the RV32 execute path.
// ALUControl encodings and execute-stage occupancy states.
package alu_pkg;

    typedef logic [2:0] alu_ctrl_t;

    localparam alu_ctrl_t ALUCTRL_ADD = 3'b000;
    localparam alu_ctrl_t ALUCTRL_SUB = 3'b001;
    localparam alu_ctrl_t ALUCTRL_AND = 3'b010;
    localparam alu_ctrl_t ALUCTRL_OR  = 3'b011;
    localparam alu_ctrl_t ALUCTRL_SLT = 3'b101;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32 ALU: ADD/SUB/AND/OR/SLT.
// Unused codes fall back to ADD.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    alu_ctrl_t ctrl;
    logic      lt;

    assign ctrl = alu_ctrl;
    assign lt   = $signed(src_a) < $signed(src_b);

    // Operation select; carry/borrow are dropped by truncation.
    always_comb begin
        result = src_a + src_b;
        unique case (ctrl)
            ALUCTRL_SUB: result = src_a - src_b;
            ALUCTRL_AND: result = src_a & src_b;
            ALUCTRL_OR:  result = src_a | src_b;
            ALUCTRL_SLT: result = {{(WIDTH-1){1'b0}}, lt};
            default:     result = src_a + src_b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_exec.sv
// Registered execute stage: ALU plus main/skid output buffer.
// Handshake outputs come straight from flops.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [TAGW-1:0]  tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [TAGW-1:0]  tag_out
);

    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;

    alu #(.WIDTH(WIDTH)) u_alu (
        .alu_ctrl (alu_ctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .result   (alu_res),
        .zero     (alu_zero)
    );

    occ_t             occ_q;
    occ_t             occ_d;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             accept;
    logic             xfer;
    logic             load_m_in;
    logic             load_m_skid;
    logic             load_s;

    logic [WIDTH-1:0] m_result;
    logic             m_zero;
    logic [TAGW-1:0]  m_tag;
    logic [WIDTH-1:0] s_result;
    logic             s_zero;
    logic [TAGW-1:0]  s_tag;

    assign accept = in_valid && in_ready_q && !flush;
    assign xfer   = out_valid_q && out_ready;

    // Occupancy next state and buffer load selects; flush empties both slots.
    always_comb begin
        occ_d       = occ_q;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_d     = OCC_ONE;
                        load_m_in = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (xfer && accept) begin
                        load_m_in = 1'b1;
                    end else if (xfer) begin
                        occ_d = OCC_EMPTY;
                    end else if (accept) begin
                        occ_d  = OCC_FULL;
                        load_s = 1'b1;
                    end
                end
                OCC_FULL: begin
                    if (xfer) begin
                        occ_d       = OCC_ONE;
                        load_m_skid = 1'b1;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    // State register with handshake flags precomputed from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q       <= OCC_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            occ_q       <= occ_d;
            out_valid_q <= (occ_d != OCC_EMPTY);
            in_ready_q  <= (occ_d != OCC_FULL);
        end
    end

    // Main slot drives the outputs, so it is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_result <= '0;
            m_zero   <= 1'b0;
            m_tag    <= '0;
        end else if (load_m_in) begin
            m_result <= alu_res;
            m_zero   <= alu_zero;
            m_tag    <= tag_in;
        end else if (load_m_skid) begin
            m_result <= s_result;
            m_zero   <= s_zero;
            m_tag    <= s_tag;
        end
    end

    // Skid slot catches the one bundle accepted during a stall.
    always_ff @(posedge clk) begin
        if (load_s) begin
            s_result <= alu_res;
            s_zero   <= alu_zero;
            s_tag    <= tag_in;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = m_result;
    assign zero      = m_zero;
    assign tag_out   = m_tag;

endmodule

// File: doc/alu_exec.md
# alu_exec

Registered execute stage of the RV32 core. It consumes the 3-bit ALUControl code from the ALU decoder together with two operands and a destination tag. It computes ADD/SUB/AND/OR/SLT and presents the result and Zero flag one cycle later through a valid/ready handshake. A two-entry output buffer (main register plus skid register) absorbs one cycle of downstream stall without combinational ready paths.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- TAGW, 5, destination-tag width (rd index)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand bundle present
- in_ready  output  1  stage can accept; driven from a register only
- alu_ctrl  input  3  ALUControl: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B
- tag_in  input  TAGW  tag carried with the bundle
- flush  input  1  synchronous discard of all held and incoming bundles
- out_valid  output  1  result bundle present
- out_ready  input  1  consumer accepts
- result  output  WIDTH  ALU result
- zero  output  1  result == 0
- tag_out  output  TAGW  tag of the presented result

## Operation
- Accept when in_valid && in_ready; transfer out when out_valid && out_ready.
- ADD and SUB are modulo 2^WIDTH; carry and borrow are discarded.
- SLT is a signed compare: result = {WIDTH-1 zeros, ($signed(src_a) < $signed(src_b))}.
- Codes 100, 110 and 111 compute ADD.
- zero is computed from the computed result and registered alongside it.
- Storage: main register M (drives outputs) and skid register S, each with a valid bit.
- Occupancy states and transitions:
  - EMPTY (M and S invalid): accept → ONE.
  - ONE (M valid, S invalid):
    - Out-transfer and accept → stays ONE; new bundle goes to M.
    - Out-transfer only → EMPTY.
    - Accept only → FULL; new bundle goes to S.
    - Neither → hold.
  - FULL (M and S valid):
    - Out-transfer → ONE; S moves to M.
    - No out-transfer → hold.
    - No accept is possible because in_ready = 0.
- in_ready = !S.valid, registered; it is 1 in EMPTY and ONE and 0 in FULL.
- The presented bundle (result/zero/tag_out) is stable while out_valid && !out_ready.
- flush: M.valid and S.valid are cleared next cycle and any same-cycle input is dropped; flush wins over accept and transfer. A same-cycle out-transfer is still counted by the consumer.

## Timing
- Reset values: out_valid=0, in_ready=1, result=0, zero=0, tag_out=0; both valid bits are 0.
- Latency: a bundle accepted at edge N is presented with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: one bundle per cycle while out_ready=1.
- Stall: one extra bundle is absorbed; in_ready falls in the cycle after the S capture.
- Release: in_ready rises in the cycle after S drains into M.
- No combinational path exists from out_ready to in_ready.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous) and in-flight bundles are lost.
- Data registers do not need reset except those that drive outputs.

## Structure
- Package alu_pkg holds:
  - ALUCTRL_ADD/SUB/AND/OR/SLT localparams, shared with the ALU decoder.
  - alu_ctrl_t typedef (logic [2:0]).
- Sub-module alu (combinational, WIDTH parameter): inputs alu_ctrl, src_a, src_b; outputs result, zero.
- alu_exec instantiates alu once on the input side and owns the M/S buffer and handshake logic.

## Test plan
- Reset: hold rst high with random inputs → out_valid=0, in_ready=1, result=0, zero=0; same values asserted asynchronously mid-stream.
- Ops, out_ready=1:
  - ADD 0x7FFFFFFF+1 → 0x80000000.
  - SUB 5-5 → 0 with zero=1.
  - AND 0xF0F0&0xFF00 → 0xF000.
  - OR → 0xFFF0.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SLT 1 vs 0xFFFFFFFF → 0.
  - Code 111 on 2,3 → 5.
- Back-to-back: 8 consecutive bundles with tags 0..7 → tags emerge in order, one per cycle, each 1 cycle after acceptance.
- Stall: hold out_ready=0 with in_valid=1 → two bundles accepted, then in_ready=0; raise out_ready → outputs drain in order and in_ready returns 1 one cycle after S drains.
- Flush: in FULL state assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the dropped bundle never appears.
- Random: constrained-random valid/ready with a scoreboard over 10k bundles → no loss, duplication or reordering, and outputs stable during stalls.
